isqrt_arbiter: RTL

//  Shares one pipelined isqrt instance among N_CLIENTS formula FSMs. Each client drives the

---
 rtl/isqrt_arb_pkg.sv | 35 +++
 rtl/isqrt_arb_tag_fifo.sv | 59 +++++
 rtl/isqrt_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/isqrt_arb_pkg.sv
// Shared types and helpers for the isqrt arbiter: data widths, client id type, round-robin pick.
package isqrt_arb_pkg;

    localparam int ISQRT_X_W   = 32;
    localparam int ISQRT_Y_W   = 16;
    localparam int MAX_CLIENTS = 8;
    localparam int CLIENT_ID_W = $clog2(MAX_CLIENTS);

    typedef logic [CLIENT_ID_W-1:0] client_id_t;

    typedef struct packed {
        logic       found;
        client_id_t id;
    } rr_pick_t;

    // First set bit of cand strictly after ptr, wrapping at n; ptr itself is checked last.
    function automatic rr_pick_t rr_pick(input logic [MAX_CLIENTS-1:0] cand,
                                         input client_id_t ptr, input int n);
        rr_pick_t   r;
        int         idx;
        client_id_t j;
        r = '0;
        for (int k = 1; k <= MAX_CLIENTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            j = client_id_t'(idx);
            if (!r.found && (k <= n) && cand[j]) begin
                r.found = 1'b1;
                r.id    = j;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/isqrt_arb_tag_fifo.sv
// In-order tag FIFO holding the issuing client id of every isqrt request still in flight.
module isqrt_arb_tag_fifo
    import isqrt_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  client_id_t push_id,
    input  logic       pop,
    output client_id_t head,
    output logic       empty,
    output logic       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    client_id_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = r_mem[r_rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/isqrt_arbiter.sv
// Round-robin sharing of one pipelined isqrt among N_CLIENTS requesters, results routed by tag.
// Optional ISQRT_ARB_BYPASS_EN lets an incoming pulse issue in its own cycle.
module isqrt_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int N_CLIENTS    = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_CLIENTS-1:0]                cl_x_vld,
    input  logic [N_CLIENTS-1:0][ISQRT_X_W-1:0] cl_x,
    output logic [N_CLIENTS-1:0]                cl_y_vld,
    output logic [ISQRT_Y_W-1:0]                cl_y,
    output logic                                isqrt_x_vld,
    output logic [ISQRT_X_W-1:0]                isqrt_x,
    input  logic                                isqrt_y_vld,
    input  logic [ISQRT_Y_W-1:0]                isqrt_y,
    output logic                                err
);

    logic [N_CLIENTS-1:0]                r_pend_vld;
    logic [N_CLIENTS-1:0][ISQRT_X_W-1:0] r_pend_x;
    client_id_t                          r_rr_ptr;
    logic                                r_err;

    logic [N_CLIENTS-1:0]                w_cand;
    logic [N_CLIENTS-1:0][ISQRT_X_W-1:0] w_cand_x;
    logic [N_CLIENTS-1:0]                w_gnt_oh;
    logic [N_CLIENTS-1:0]                w_load;
    logic [N_CLIENTS-1:0]                w_ovf;
    logic [MAX_CLIENTS-1:0]              w_cand_ext;
    rr_pick_t                            w_pick;
    logic                                w_grant;
    logic                                w_can_push;
    logic                                w_pop;
    logic                                w_empty;
    logic                                w_full;
    client_id_t                          w_head;

    genvar gi;
    generate
        for (gi = 0; gi < N_CLIENTS; gi++) begin : g_client
`ifdef ISQRT_ARB_BYPASS_EN
            assign w_cand[gi] = r_pend_vld[gi] | cl_x_vld[gi];
`else
            assign w_cand[gi] = r_pend_vld[gi];
`endif
            // A pending request always takes precedence over the same client's new pulse.
            assign w_cand_x[gi] = r_pend_vld[gi] ? r_pend_x[gi] : cl_x[gi];
            assign w_gnt_oh[gi] = w_grant && (w_pick.id == client_id_t'(gi));
            assign w_load[gi]   = cl_x_vld[gi] && (r_pend_vld[gi] ? w_gnt_oh[gi] : !w_gnt_oh[gi]);
            assign w_ovf[gi]    = cl_x_vld[gi] && r_pend_vld[gi] && !w_gnt_oh[gi];
            assign cl_y_vld[gi] = w_pop && (w_head == client_id_t'(gi));
        end
    endgenerate

    assign w_cand_ext  = MAX_CLIENTS'(w_cand);
    assign w_pick      = rr_pick(w_cand_ext, r_rr_ptr, N_CLIENTS);
    assign w_pop       = isqrt_y_vld && !w_empty;
    assign w_can_push  = !w_full || w_pop;
    assign w_grant     = rst_n && w_pick.found && w_can_push;
    assign isqrt_x_vld = w_grant;
    assign cl_y        = isqrt_y;
    assign err         = r_err;

    always_comb begin
        isqrt_x = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (w_gnt_oh[i]) isqrt_x = isqrt_x | w_cand_x[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld <= '0;
            r_pend_x   <= '0;
            r_rr_ptr   <= client_id_t'(N_CLIENTS - 1);
            r_err      <= 1'b0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (w_load[i]) begin
                    r_pend_vld[i] <= 1'b1;
                    r_pend_x[i]   <= cl_x[i];
                end else if (w_gnt_oh[i]) begin
                    r_pend_vld[i] <= 1'b0;
                end
            end
            if (w_grant) r_rr_ptr <= w_pick.id;
            if ((|w_ovf) || (isqrt_y_vld && w_empty)) r_err <= 1'b1;
        end
    end

    isqrt_arb_tag_fifo #(
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_grant),
        .push_id (w_pick.id),
        .pop     (w_pop),
        .head    (w_head),
        .empty   (w_empty),
        .full    (w_full)
    );

endmodule
